// File: rtl/tone_player_pkg.sv
// ----------------------------------------------------------------------------
// tone_player_pkg
// Shared definitions for the polyphonic tone player: playback FSM state type,
// default clock/beat rates and elaboration-time sizing helpers.
// ----------------------------------------------------------------------------
package tone_player_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_PAUSE
    } state_t;

    localparam int unsigned DEF_CLK_FREQ  = 100_000_000;
    localparam int unsigned DEF_BEAT_FREQ = 9;

    // Clock cycles per beat (integer division).
    function automatic int unsigned beat_div(input int unsigned clk_freq,
                                             input int unsigned beat_freq);
        return clk_freq / beat_freq;
    endfunction

    // Phase accumulator width. acc < CLK_FREQ and the step is at most
    // CLK_FREQ/2, so the pre-wrap sum stays below 2*CLK_FREQ.
    function automatic int unsigned acc_width(input int unsigned clk_freq);
        return $clog2(clk_freq) + 1;
    endfunction

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tone_nco.sv
// ----------------------------------------------------------------------------
// tone_nco
// One tone channel: latches and saturates a tone word, runs a phase
// accumulator and produces a 50% duty square wave at the tone frequency.
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-low reset
//   clear    in   zero tone latch, accumulator and wave (song start/stop)
//   load     in   latch tone_in this cycle
//   advance  in   step the accumulator this cycle (PLAY)
//   out_en   in   wave visible on pwm next cycle, else pwm forced low
//   tone_in  in   requested tone in Hz, 0 = rest
//   pwm      out  registered square wave
// ----------------------------------------------------------------------------
module tone_nco
    import tone_player_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned FREQ_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic              advance,
    input  logic              out_en,
    input  logic [FREQ_W-1:0] tone_in,
    output logic              pwm
);

    localparam int unsigned       ACC_W       = acc_width(CLK_FREQ);
    localparam logic [ACC_W-1:0]  WRAP        = ACC_W'(CLK_FREQ);
    localparam logic [ACC_W-1:0]  TONE_MAX    = ACC_W'(CLK_FREQ / 4);
    localparam logic [FREQ_W-1:0] TONE_MAX_IN = FREQ_W'(CLK_FREQ / 4);

    logic [ACC_W-1:0] tone_q, tone_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sum;
    logic             phase_q, phase_d;

    always_comb begin
        tone_d  = tone_q;
        acc_d   = acc_q;
        phase_d = phase_q;
        // Adding twice the tone per cycle against a CLK_FREQ wrap toggles
        // the wave at 2*tone Hz, i.e. a square wave at tone Hz.
        sum     = acc_q + (tone_q << 1);

        if (clear) begin
            tone_d  = '0;
            acc_d   = '0;
            phase_d = 1'b0;
        end else begin
            if (load) begin
                tone_d = (tone_in > TONE_MAX_IN) ? TONE_MAX : ACC_W'(tone_in);
            end
            if (tone_q == '0) begin
                acc_d   = '0;
                phase_d = 1'b0;
            end else if (advance) begin
                if (sum >= WRAP) begin
                    acc_d   = sum - WRAP;
                    phase_d = ~phase_q;
                end else begin
                    acc_d   = sum;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tone_q  <= '0;
            acc_q   <= '0;
            phase_q <= 1'b0;
            pwm     <= 1'b0;
        end else begin
            tone_q  <= tone_d;
            acc_q   <= acc_d;
            phase_q <= phase_d;
            pwm     <= out_en & phase_d;
        end
    end

endmodule

// File: rtl/poly_tone_player.sv
// ----------------------------------------------------------------------------
// poly_tone_player
// Beat-sequenced polyphonic square-wave player. Steps a beat index that
// addresses an external song ROM, latches one tone per channel per beat and
// mixes the enabled channel waves onto one PWM output.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   start      in   pulse: (re)start song at beat 0
//   stop       in   pulse: abort to idle (wins over start and pause)
//   pause      in   level: hold playback while high
//   loop_en    in   wrap to beat 0 at song end instead of stopping
//   ch_en      in   per-channel mute mask, 1 = audible
//   tone_in    in   per-channel tone for beat_idx, channel 0 in LSBs
//   beat_idx   out  current beat
//   beat_tick  out  one-cycle pulse at each beat boundary
//   pwm_ch     out  per-channel square waves
//   pwm_mix    out  OR of enabled channel waves
//   playing    out  high in PLAY or PAUSE
//   done       out  one-cycle pulse at non-looping song end
// ----------------------------------------------------------------------------
module poly_tone_player
    import tone_player_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
    parameter int unsigned BEAT_FREQ = DEF_BEAT_FREQ,
    parameter int unsigned NUM_BEATS = 128,
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned FREQ_W    = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         pause,
    input  logic                         loop_en,
    input  logic [NUM_CH-1:0]            ch_en,
    input  logic [NUM_CH*FREQ_W-1:0]     tone_in,
    output logic [$clog2(NUM_BEATS)-1:0] beat_idx,
    output logic                         beat_tick,
    output logic [NUM_CH-1:0]            pwm_ch,
    output logic                         pwm_mix,
    output logic                         playing,
    output logic                         done
);

    localparam int unsigned BEAT_DIV = beat_div(CLK_FREQ, BEAT_FREQ);
    localparam int unsigned DIV_W    = cnt_width(BEAT_DIV);
    localparam int unsigned IDX_W    = $clog2(NUM_BEATS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BEAT_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BEATS - 1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [IDX_W-1:0] idx_d;
    logic             beat_end;
    logic             song_end;
    logic             load_q;
    logic             nco_clear;
    logic             nco_adv;
    logic             out_en;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        idx_d     = beat_idx;
        beat_end  = (state_q == ST_PLAY) && !stop && !start && (div_q == DIV_LAST);
        song_end  = beat_end && (beat_idx == IDX_LAST) && !loop_en;
        nco_clear = stop || start || song_end;
        nco_adv   = (state_q == ST_PLAY);

        if (stop) begin
            state_d = ST_IDLE;
            div_d   = '0;
            idx_d   = '0;
        end else if (start) begin
            state_d = ST_PLAY;
            div_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    // The divider still steps in the cycle pause is seen;
                    // the freeze applies from the first PAUSE cycle.
                    div_d = beat_end ? '0 : div_q + 1'b1;
                    if (beat_end) begin
                        idx_d = (beat_idx == IDX_LAST) ? '0 : beat_idx + 1'b1;
                    end
                    if (song_end) begin
                        state_d = ST_IDLE;
                    end else if (pause) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (!pause) begin
                        state_d = ST_PLAY;
                    end
                end
                default: ;
            endcase
        end

        out_en = (state_d == ST_PLAY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            beat_idx  <= '0;
            load_q    <= 1'b0;
            beat_tick <= 1'b0;
            done      <= 1'b0;
            playing   <= 1'b0;
            pwm_mix   <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            beat_idx  <= idx_d;
            // Tone latch trails the beat_idx update by one cycle so the
            // external ROM has presented the new beat's tones.
            load_q    <= (start && !stop) || (beat_end && !song_end);
            beat_tick <= beat_end;
            done      <= song_end;
            playing   <= (state_d != ST_IDLE);
            pwm_mix   <= |(pwm_ch & ch_en);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tone_nco #(
            .CLK_FREQ (CLK_FREQ),
            .FREQ_W   (FREQ_W)
        ) u_nco (
            .clk     (clk),
            .reset   (reset),
            .clear   (nco_clear),
            .load    (load_q),
            .advance (nco_adv),
            .out_en  (out_en),
            .tone_in (tone_in[g*FREQ_W +: FREQ_W]),
            .pwm     (pwm_ch[g])
        );
    end

endmodule

// File: tb/tb_poly_tone_player.sv
// ----------------------------------------------------------------------------
// tb_poly_tone_player
// Directed bench for poly_tone_player with CLK_FREQ=1000, BEAT_FREQ=100
// (10 cycles per beat), NUM_BEATS=4, NUM_CH=2. Expectations are queued with
// the edge number (relative to the start edge) at which they must hold and
// are compared on the following falling edge.
// ----------------------------------------------------------------------------
module tb_poly_tone_player;

    localparam int unsigned CLK_FREQ  = 1000;
    localparam int unsigned BEAT_FREQ = 100;
    localparam int unsigned NUM_BEATS = 4;
    localparam int unsigned NUM_CH    = 2;
    localparam int unsigned FREQ_W    = 32;

    localparam int unsigned S_IDX  = 0;
    localparam int unsigned S_TICK = 1;
    localparam int unsigned S_PWM  = 2;
    localparam int unsigned S_MIX  = 3;
    localparam int unsigned S_PLAY = 4;
    localparam int unsigned S_DONE = 5;

    logic                     clk     = 1'b0;
    logic                     reset   = 1'b0;
    logic                     start   = 1'b0;
    logic                     stop    = 1'b0;
    logic                     pause   = 1'b0;
    logic                     loop_en = 1'b0;
    logic [NUM_CH-1:0]        ch_en   = 2'b11;
    logic [NUM_CH*FREQ_W-1:0] tone_in = '0;
    logic [1:0]               beat_idx;
    logic                     beat_tick;
    logic [NUM_CH-1:0]        pwm_ch;
    logic                     pwm_mix;
    logic                     playing;
    logic                     done;

    poly_tone_player #(
        .CLK_FREQ  (CLK_FREQ),
        .BEAT_FREQ (BEAT_FREQ),
        .NUM_BEATS (NUM_BEATS),
        .NUM_CH    (NUM_CH),
        .FREQ_W    (FREQ_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .loop_en   (loop_en),
        .ch_en     (ch_en),
        .tone_in   (tone_in),
        .beat_idx  (beat_idx),
        .beat_tick (beat_tick),
        .pwm_ch    (pwm_ch),
        .pwm_mix   (pwm_mix),
        .playing   (playing),
        .done      (done)
    );

    always #5 clk = ~clk;

    int unsigned edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int unsigned cyc;
        int unsigned sig;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t        sbq[$];
    int unsigned t0     = 0;
    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned fails  = 0;

    function automatic logic [31:0] b(input logic x);
        return {31'd0, x};
    endfunction

    // Square wave expected k edges after start for a given tone: tone is
    // latched at edge 1, accumulation starts at edge 2, half period
    // CLK_FREQ/(2*tone) cycles, tone saturated at CLK_FREQ/4.
    function automatic logic wave_at(input int unsigned k, input int unsigned tone);
        int unsigned t;
        int unsigned p;
        t = (tone > CLK_FREQ / 4) ? CLK_FREQ / 4 : tone;
        if (t == 0 || k < 1) return 1'b0;
        p = CLK_FREQ / (2 * t);
        return (((k - 1) / p) % 2) == 1;
    endfunction

    function automatic logic [31:0] sample(input int unsigned sig);
        case (sig)
            S_IDX:   return {30'd0, beat_idx};
            S_TICK:  return b(beat_tick);
            S_PWM:   return {30'd0, pwm_ch};
            S_MIX:   return b(pwm_mix);
            S_PLAY:  return b(playing);
            default: return b(done);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic expect_at(input int unsigned k, input int unsigned sig,
                             input logic [31:0] val, input string tag);
        exp_t e;
        e.cyc = t0 + k;
        e.sig = sig;
        e.val = val;
        e.tag = $sformatf("%s@%0d", tag, k);
        sbq.push_back(e);
    endtask

    task automatic drain();
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc == edge_n) begin
                check(sbq[i].tag, sample(sbq[i].sig), sbq[i].val);
                sbq.delete(i);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        drain();
    endtask

    task automatic start_pulse();
        start = 1'b1;
        t0    = edge_n + 1;
        tick();
        start = 1'b0;
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        logic w;
        logic wp;

        // Reset state
        repeat (2) tick();
        check("rst_playing", b(playing), 32'd0);
        check("rst_beat_idx", {30'd0, beat_idx}, 32'd0);
        check("rst_pwm_ch", {30'd0, pwm_ch}, 32'd0);
        check("rst_pwm_mix", b(pwm_mix), 32'd0);
        check("rst_tick", b(beat_tick), 32'd0);
        check("rst_done", b(done), 32'd0);
        reset = 1'b1;
        repeat (3) tick();
        check("idle_after_release", b(playing), 32'd0);

        // Non-looping song, ch0=100 Hz, ch1 rest
        tone_in = {32'd0, 32'd100};
        loop_en = 1'b0;
        ch_en   = 2'b11;
        start_pulse();
        for (int unsigned k = 1; k <= 45; k++) begin
            w  = (k < 40) ? wave_at(k, 100) : 1'b0;
            wp = (k - 1 < 40) ? wave_at(k - 1, 100) : 1'b0;
            expect_at(k, S_TICK, b(k % 10 == 0 && k <= 40), "t1_tick");
            expect_at(k, S_DONE, b(k == 40), "t1_done");
            expect_at(k, S_PLAY, b(k < 40), "t1_playing");
            expect_at(k, S_IDX, (k < 40) ? k / 10 : 0, "t1_beat_idx");
            expect_at(k, S_PWM, {31'd0, w}, "t1_pwm_ch");
            if (k >= 2) expect_at(k, S_MIX, b(wp), "t1_pwm_mix");
        end
        repeat (45) tick();

        // Looping song
        loop_en = 1'b1;
        start_pulse();
        for (int unsigned k = 1; k <= 45; k++) begin
            expect_at(k, S_TICK, b(k % 10 == 0), "t2_tick");
            expect_at(k, S_DONE, 32'd0, "t2_done");
            expect_at(k, S_PLAY, 32'd1, "t2_playing");
            expect_at(k, S_IDX, (k / 10) % 4, "t2_beat_idx");
            expect_at(k, S_PWM, {31'd0, wave_at(k, 100)}, "t2_pwm_ch");
        end
        repeat (45) tick();
        expect_at(46, S_PLAY, 32'd0, "t2_stop_playing");
        expect_at(46, S_IDX, 32'd0, "t2_stop_beat_idx");
        expect_at(46, S_PWM, 32'd0, "t2_stop_pwm_ch");
        stop_pulse();

        // Pause over edges 13..32
        loop_en = 1'b0;
        start_pulse();
        for (int unsigned k = 1; k <= 12; k++)
            expect_at(k, S_PWM, {31'd0, wave_at(k, 100)}, "t3_pwm_ch");
        for (int unsigned k = 13; k <= 35; k++)
            expect_at(k, S_PWM, 32'd0, "t3_pwm_ch_held");
        for (int unsigned k = 36; k <= 40; k++)
            expect_at(k, S_PWM, 32'd1, "t3_pwm_ch_resumed");
        for (int unsigned k = 11; k <= 39; k++)
            expect_at(k, S_IDX, 32'd1, "t3_beat_idx");
        for (int unsigned k = 13; k <= 40; k++)
            expect_at(k, S_PLAY, 32'd1, "t3_playing");
        expect_at(20, S_TICK, 32'd0, "t3_tick");
        expect_at(30, S_TICK, 32'd0, "t3_tick");
        expect_at(40, S_TICK, 32'd1, "t3_tick");
        expect_at(40, S_IDX, 32'd2, "t3_beat_idx");
        for (int unsigned k = 1; k <= 41; k++) begin
            pause = (k >= 13 && k <= 32);
            tick();
        end
        pause = 1'b0;
        stop_pulse();

        // Tone change mid-beat, then start+stop together
        tone_in = {32'd0, 32'd100};
        start_pulse();
        for (int unsigned k = 1; k <= 10; k++)
            expect_at(k, S_PWM, {31'd0, wave_at(k, 100)}, "t4_pwm_ch_old");
        for (int unsigned k = 11; k <= 19; k++)
            expect_at(k, S_PWM, b((((k - 11) / 2) % 2) == 1), "t4_pwm_ch_new");
        for (int unsigned k = 20; k <= 25; k++) begin
            expect_at(k, S_PLAY, 32'd0, "t4_playing");
            expect_at(k, S_IDX, 32'd0, "t4_beat_idx");
            expect_at(k, S_PWM, 32'd0, "t4_pwm_ch");
            expect_at(k, S_TICK, 32'd0, "t4_tick");
        end
        for (int unsigned k = 1; k <= 25; k++) begin
            if (k >= 5) tone_in = {32'd0, 32'd400};
            start = (k == 20);
            stop  = (k == 20);
            tick();
        end
        start = 1'b0;
        stop  = 1'b0;

        // Mute mask, then saturation
        ch_en   = 2'b10;
        tone_in = {32'd100, 32'd100};
        start_pulse();
        for (int unsigned k = 1; k <= 20; k++) begin
            w = wave_at(k, 100);
            expect_at(k, S_PWM, {30'd0, w, w}, "t5_pwm_ch");
            if (k >= 2) expect_at(k, S_MIX, b(wave_at(k - 1, 100)), "t5_pwm_mix");
        end
        repeat (20) tick();
        stop_pulse();
        ch_en   = 2'b11;
        tone_in = {32'd0, 32'd400};
        start_pulse();
        for (int unsigned k = 1; k <= 12; k++) begin
            expect_at(k, S_PWM, {31'd0, wave_at(k, 400)}, "t5_pwm_sat");
            if (k >= 2) expect_at(k, S_MIX, b(wave_at(k - 1, 400)), "t5_mix_sat");
        end
        repeat (12) tick();
        stop_pulse();

        // Reset mid-play
        tone_in = {32'd0, 32'd100};
        start_pulse();
        expect_at(17, S_PLAY, 32'd1, "t6_playing_pre");
        expect_at(17, S_PWM, 32'd1, "t6_pwm_pre");
        repeat (17) tick();
        #2 reset = 1'b0;
        #1;
        check("t6_rst_playing", b(playing), 32'd0);
        check("t6_rst_beat_idx", {30'd0, beat_idx}, 32'd0);
        check("t6_rst_pwm_ch", {30'd0, pwm_ch}, 32'd0);
        check("t6_rst_pwm_mix", b(pwm_mix), 32'd0);
        tick();
        reset = 1'b1;
        t0 = edge_n;
        for (int unsigned k = 1; k <= 25; k++) begin
            expect_at(k, S_PLAY, 32'd0, "t6_idle_playing");
            expect_at(k, S_IDX, 32'd0, "t6_idle_beat_idx");
            expect_at(k, S_TICK, 32'd0, "t6_idle_tick");
            expect_at(k, S_PWM, 32'd0, "t6_idle_pwm_ch");
        end
        repeat (25) tick();

        while (sbq.size() > 0) begin
            checks++;
            fails++;
            $error("FAIL %s: observed never-sampled expected sampled", sbq[0].tag);
            sbq.delete(0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
